// File: rtl/beep_mixer.sv
// beep_mixer: selects background music by gamemode and overlays one-shot
// sound-effect tones (with a trailing silent gap) onto the single buzzer output.
// Optional feature macro: BEEP_MIXER_VOLUME_EN adds a 2-bit vol input that
// gates the buzzer with a 16-step PWM duty.
module beep_mixer #(
    parameter int unsigned TICK_1MS   = 99999,
    parameter int unsigned SFX_LEN_MS = 120,
    parameter int unsigned GAP_MS     = 10,
    parameter int unsigned SFX0_HALF  = 113636,
    parameter int unsigned SFX1_HALF  = 85179,
    parameter int unsigned SFX2_HALF  = 63776,
    parameter int unsigned SFX3_HALF  = 191113
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gamemode,
    input  logic       music_start,
    input  logic       music_play,
    input  logic       music_over,
    input  logic       mute,
`ifdef BEEP_MIXER_VOLUME_EN
    input  logic [1:0] vol,
`endif
    input  logic       sfx_req,
    input  logic [1:0] sfx_id,
    output logic       sfx_busy,
    output logic       sfx_drop,
    output logic       beep
);

    localparam int unsigned TICK_W = 17;
    localparam int unsigned MS_W   = 10;
    localparam int unsigned TONE_W = 18;

    typedef enum logic [1:0] {
        ST_MUSIC = 2'd0,
        ST_SFX   = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [MS_W-1:0]     ms_cnt;
    logic [TONE_W-1:0]   tone_cnt;
    logic [1:0]          id_q;
    logic                sfx_wave;

    logic                music_sel;
    logic                raw;
    logic [TONE_W-1:0]   half_max;
    logic                tick_wrap;
    logic                tone_wrap;
    logic                sfx_last_ms;
    logic                gap_last_ms;

    // Background music select from current gamemode
    always_comb begin
        music_sel = 1'b0;
        case (gamemode)
            2'b00:   music_sel = music_start;
            2'b01:   music_sel = music_play;
            2'b10:   music_sel = music_over;
            default: music_sel = 1'b0;
        endcase
    end

    // Terminal tone count for the latched effect
    always_comb begin
        half_max = TONE_W'(SFX0_HALF - 1);
        case (id_q)
            2'd0:    half_max = TONE_W'(SFX0_HALF - 1);
            2'd1:    half_max = TONE_W'(SFX1_HALF - 1);
            2'd2:    half_max = TONE_W'(SFX2_HALF - 1);
            default: half_max = TONE_W'(SFX3_HALF - 1);
        endcase
    end

    assign tick_wrap   = (tick_cnt == TICK_W'(TICK_1MS));
    assign tone_wrap   = (tone_cnt == half_max);
    assign sfx_last_ms = (ms_cnt == MS_W'(SFX_LEN_MS - 1));
    assign gap_last_ms = (ms_cnt == MS_W'(GAP_MS - 1));

    // Pre-mute buzzer level for the current state
    always_comb begin
        raw = 1'b0;
        case (state)
            ST_MUSIC: raw = music_sel;
            ST_SFX:   raw = sfx_wave;
            default:  raw = 1'b0;
        endcase
    end

    // Effect sequencer: MUSIC -> SFX (tone for SFX_LEN_MS) -> GAP (silence) -> MUSIC
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_MUSIC;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            tone_cnt <= '0;
            id_q     <= '0;
            sfx_wave <= 1'b0;
            sfx_busy <= 1'b0;
            sfx_drop <= 1'b0;
        end else begin
            // sfx_busy mirrors state != MUSIC, so a request seen while busy is dropped
            sfx_drop <= sfx_req && sfx_busy;
            case (state)
                ST_MUSIC: begin
                    if (sfx_req) begin
                        id_q     <= sfx_id;
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                        tone_cnt <= '0;
                        sfx_wave <= 1'b0;
                        sfx_busy <= 1'b1;
                        state    <= ST_SFX;
                    end
                end
                ST_SFX: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                    tone_cnt <= tone_wrap ? '0 : tone_cnt + TONE_W'(1);
                    if (tone_wrap) begin
                        sfx_wave <= ~sfx_wave;
                    end
                    if (tick_wrap) begin
                        if (sfx_last_ms) begin
                            ms_cnt   <= '0;
                            tone_cnt <= '0;
                            sfx_wave <= 1'b0;
                            state    <= ST_GAP;
                        end else begin
                            ms_cnt <= ms_cnt + MS_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                    if (tick_wrap) begin
                        if (gap_last_ms) begin
                            ms_cnt   <= '0;
                            sfx_busy <= 1'b0;
                            state    <= ST_MUSIC;
                        end else begin
                            ms_cnt <= ms_cnt + MS_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_MUSIC;
                    sfx_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef BEEP_MIXER_VOLUME_EN
    logic [3:0] pwm_cnt;
    logic [4:0] pwm_thr;

    // Duty threshold: 0/16, 4/16, 8/16, 16/16
    always_comb begin
        pwm_thr = 5'd16;
        case (vol)
            2'b00:   pwm_thr = 5'd0;
            2'b01:   pwm_thr = 5'd4;
            2'b10:   pwm_thr = 5'd8;
            default: pwm_thr = 5'd16;
        endcase
    end

    // Free-running PWM phase
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'(1);
        end
    end

    // Registered buzzer drive with mute and volume gating
    always_ff @(posedge clk) begin
        if (rst) begin
            beep <= 1'b0;
        end else begin
            beep <= !mute && raw && ({1'b0, pwm_cnt} < pwm_thr);
        end
    end
`else
    // Registered buzzer drive with mute gating
    always_ff @(posedge clk) begin
        if (rst) begin
            beep <= 1'b0;
        end else begin
            beep <= !mute && raw;
        end
    end
`endif

endmodule

// File: tb/tb_beep_mixer.sv
// Scoreboard bench for beep_mixer with scaled-down timing parameters.
module tb_beep_mixer;

    localparam int unsigned P_TICK = 4;
    localparam int unsigned P_LEN  = 6;
    localparam int unsigned P_GAP  = 2;
    localparam int unsigned P_H0   = 1;
    localparam int unsigned P_H1   = 2;
    localparam int unsigned P_H2   = 3;
    localparam int unsigned P_H3   = 5;

    localparam int CYC_MS  = P_TICK + 1;
    localparam int SFX_CYC = P_LEN * CYC_MS;
    localparam int GAP_CYC = P_GAP * CYC_MS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gamemode = 2'b00;
    logic       music_start = 1'b0;
    logic       music_play = 1'b0;
    logic       music_over = 1'b0;
    logic       mute = 1'b0;
    logic [1:0] vol = 2'b11;
    logic       sfx_req = 1'b0;
    logic [1:0] sfx_id = 2'b00;
    logic       sfx_busy;
    logic       sfx_drop;
    logic       beep;

    always #5 clk = ~clk;

    beep_mixer #(
        .TICK_1MS  (P_TICK),
        .SFX_LEN_MS(P_LEN),
        .GAP_MS    (P_GAP),
        .SFX0_HALF (P_H0),
        .SFX1_HALF (P_H1),
        .SFX2_HALF (P_H2),
        .SFX3_HALF (P_H3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gamemode   (gamemode),
        .music_start(music_start),
        .music_play (music_play),
        .music_over (music_over),
        .mute       (mute),
`ifdef BEEP_MIXER_VOLUME_EN
        .vol        (vol),
`endif
        .sfx_req    (sfx_req),
        .sfx_id     (sfx_id),
        .sfx_busy   (sfx_busy),
        .sfx_drop   (sfx_drop),
        .beep       (beep)
    );

    typedef struct packed {
        logic beep;
        logic busy;
        logic drop;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: effect described by its age (clocks since acceptance)
    bit   m_busy = 1'b0;
    int   m_age  = 0;
    int   m_id   = 0;
    int   m_pwm  = 0;

    // Stimulus knobs
    logic [1:0] g_gm    = 2'b00;
    logic       g_mute  = 1'b0;
    logic [1:0] g_vol   = 2'b11;
    int         g_music = 0;  // 0 random, 1 all high, 2 toggle

    function automatic int half_of(input int id);
        case (id)
            0:       return P_H0;
            1:       return P_H1;
            2:       return P_H2;
            default: return P_H3;
        endcase
    endfunction

    function automatic int thr_of(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Drive one clock of inputs and push the outputs expected after that edge
    task automatic step(input bit r, input bit rq, input logic [1:0] id);
        bit   raw_now;
        bit   mus;
        exp_t e;
        @(negedge clk);
        rst      = r;
        gamemode = g_gm;
        mute     = g_mute;
        vol      = g_vol;
        sfx_req  = rq;
        sfx_id   = id;
        case (g_music)
            1: begin
                music_start = 1'b1; music_play = 1'b1; music_over = 1'b1;
            end
            2: begin
                music_start = ~music_start; music_play = ~music_play; music_over = ~music_over;
            end
            default: begin
                music_start = 1'($urandom_range(0, 1));
                music_play  = 1'($urandom_range(0, 1));
                music_over  = 1'($urandom_range(0, 1));
            end
        endcase
        case (g_gm)
            2'b00:   mus = music_start;
            2'b01:   mus = music_play;
            2'b10:   mus = music_over;
            default: mus = 1'b0;
        endcase
        if (!m_busy)          raw_now = mus;
        else if (m_age < SFX_CYC) raw_now = ((m_age / half_of(m_id)) % 2) == 1;
        else                  raw_now = 1'b0;
`ifdef BEEP_MIXER_VOLUME_EN
        if (m_pwm >= thr_of(g_vol)) raw_now = 1'b0;
`endif
        if (r) begin
            e.beep = 1'b0;
            e.drop = 1'b0;
            m_busy = 1'b0;
            m_age  = 0;
            m_pwm  = 0;
        end else begin
            e.beep = !g_mute && raw_now;
            e.drop = rq && m_busy;
            if (!m_busy && rq) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = int'(id);
            end else if (m_busy) begin
                m_age++;
                if (m_age == SFX_CYC + GAP_CYC) m_busy = 1'b0;
            end
            m_pwm = (m_pwm + 1) % 16;
        end
        e.busy = m_busy;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'b00);
    endtask

    // Issue nothing until the model says the effect has ended (bounded)
    task automatic wait_idle();
        int k;
        k = 0;
        while (m_busy && k < 200) begin
            step(1'b0, 1'b0, 2'b00);
            k++;
        end
        n_tests++;
        if (m_busy) begin
            n_fail++;
            $display("FAIL wait_idle: effect still active after %0d clocks, required end", k);
        end
    endtask

    // Monitor: compare every registered output once per clock
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests += 3;
                if (beep !== e.beep) begin
                    n_fail++;
                    $display("FAIL beep @%0t: got %b required %b", $time, beep, e.beep);
                end
                if (sfx_busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL sfx_busy @%0t: got %b required %b", $time, sfx_busy, e.busy);
                end
                if (sfx_drop !== e.drop) begin
                    n_fail++;
                    $display("FAIL sfx_drop @%0t: got %b required %b", $time, sfx_drop, e.drop);
                end
            end
        end
    end

    initial begin
        // Reset with toggling start-screen music, then music follows
        g_gm = 2'b00; g_music = 2;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2'b00);
        idle(8);

        // Paused selects silence; game-over selects music_over
        g_gm = 2'b11; g_music = 1;
        idle(5);
        g_gm = 2'b10; g_music = 0;
        idle(10);

        // Effect 0, second request 5 ms in is dropped, gamemode change mid-effect
        g_gm = 2'b01;
        step(1'b0, 1'b1, 2'b00);
        idle(5 * CYC_MS - 1);
        step(1'b0, 1'b1, 2'b10);
        g_gm = 2'b00;
        wait_idle();
        // Request on the first MUSIC clock is accepted
        step(1'b0, 1'b1, 2'b11);

        // Muted effect still ends on time
        g_mute = 1'b1;
        wait_idle();
        g_mute = 1'b0;
        idle(4);

        // Each effect id once, back to back
        for (int id = 0; id < 4; id++) begin
            step(1'b0, 1'b1, 2'(id));
            wait_idle();
        end

        // Reset mid-effect aborts it
        step(1'b0, 1'b1, 2'b01);
        idle(10);
        step(1'b1, 1'b0, 2'b00);
        idle(6);

`ifdef BEEP_MIXER_VOLUME_EN
        // Volume steps with raw held high
        g_gm = 2'b00; g_music = 1;
        for (int v = 0; v < 4; v++) begin
            g_vol = 2'(v);
            idle(32);
        end
        g_music = 0;
`endif

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) g_gm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) g_mute = ~g_mute;
            if ($urandom_range(0, 149) == 0) g_vol = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 24) == 0),
                 2'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
